dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Two-port arbiter that shares the single hm515264 DRAM command interface (ena/ack/busy handshake, 256k x 4) between requesters.
- Client 0 is the Turing-machine tape engine; client 1 is a tape-dump/viewer engine feeding the max7219 display path.
- Latches the winner's command, drives the memory handshake and returns a one-cycle done pulse with read data.
- Round-robin grant; neither client can starve the other.

Parameters:
- ABITS, 18, DRAM word address width.
- DBITS, 4, DRAM data width.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- c0_req  in  1  client 0 request, level, held until c0_done
- c0_write  in  1  client 0: 1 = write, 0 = read
- c0_addr  in  ABITS  client 0 address
- c0_wdata  in  DBITS  client 0 write data
- c0_done  out  1  one-cycle pulse: client 0 operation complete
- c1_req, c1_write, c1_addr, c1_wdata, c1_done  same as client 0, for client 1
- rdata  out  DBITS  read data, valid in the cycle of either done pulse
- owner  out  1  client of the current or most recent grant
- m_ena  out  1  memory command enable
- m_write  out  1  memory write select
- m_addr  out  ABITS  memory address
- wr_data  out  DBITS  memory write data
- m_ack  in  1  memory: command accepted (1-cycle pulse)
- m_busy  in  1  memory: operation or init/refresh in progress
- rd_data  in  DBITS  memory read data

Behaviour:
- Reset (async, rst_n=0): state IDLE. m_ena=0, m_write=0, m_addr=0, wr_data=0, c0_done=0, c1_done=0, rdata=0, owner=0, last=1 (so client 0 wins the first tie).
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No grant while m_busy=1; this covers DRAM power-up init and refresh.
  - With m_busy=0 and any req: grant one client.
  - Only one req: grant it. Both req: grant !last.
  - On grant, same edge: latch the client's addr/write/wdata into m_addr/m_write/wr_data, set owner and last to the winner, m_ena<=1, go to ISSUE.
- ISSUE:
  - m_ena, m_addr, m_write and wr_data held stable.
  - On m_ack: m_ena<=0.
    - Read: capture rd_data into rdata (bypass for 1-cycle memory).
    - If m_busy=1 in the ack cycle, go to WAIT; otherwise go to DONE.
  - No timeout; ISSUE waits for m_ack indefinitely.
- WAIT:
  - For reads, rdata<=rd_data every cycle.
  - When m_busy=0, go to DONE.
- DONE:
  - Pulse the owner's done for exactly one cycle; rdata stable during it. m_write<=0. Go to IDLE.
  - Earliest re-grant is the cycle after DONE.
  - A client that keeps req high after its done is treated as a new request.
- Latency: req sampled in IDLE → m_ena high the next cycle. With 1-cycle memory (ack at first m_ena cycle, busy low), done is asserted 3 cycles after req is first sampled.
- Writes leave rdata unchanged.
- Never more than one done high in any cycle; done is never high outside DONE.
- Requester drops req after grant: the operation completes and done still pulses. Dropped before grant: ignored.
- Request arriving for the non-owner during ISSUE/WAIT/DONE: served in the next IDLE. Round robin bounds its wait to one operation.
- Address wrap is the client's responsibility; the arbiter passes addresses unmodified.
- rst_n asserted mid-operation: immediate return to reset values, including m_ena=0. The memory controller is reset by the same rst_n. No done for the aborted operation.

Test Plan:
- Init hold: m_busy=1 for 100 cycles after reset with c0_req=1 → m_ena stays 0; m_ena rises the cycle after m_busy falls; m_addr equals c0_addr.
- Single read, 1-cycle memory: c0 read addr 0x00005, memory acks on the first m_ena cycle with busy=0 and rd_data=4'hA → c0_done pulses once, rdata=4'hA, exactly 3 cycles after req is sampled; c1_done stays 0.
- Slow write: c1 write addr 0x3FFFF data 4'h3, ack after 4 cycles, busy high 6 more cycles → m_addr/wr_data/m_write constant from grant to done; c1_done after busy falls; rdata unchanged.
- Contention: c0_req and c1_req high continuously, all reads → grants alternate 0,1,0,1 after reset; owner toggles; 8 ops give 4 done pulses per client.
- Drop after grant: c1 read granted, c1_req dropped in ISSUE → operation completes and c1_done pulses; a pending c0 is served next.
- Reset mid-op: rst_n low during WAIT → m_ena=0, no done, owner=0; after release, a fresh c0 request is served normally.

Source files
------------

// File: rtl/dram_arbiter_if.sv
// Bundle of the two client request ports and the hm515264 command handshake.
// The arbiter connects through the slave modport; clients and memory use master.
interface dram_arbiter_if #(
   parameter int ABITS = 18,
   parameter int DBITS = 4
);
   logic             c0_req;
   logic             c0_write;
   logic [ABITS-1:0] c0_addr;
   logic [DBITS-1:0] c0_wdata;
   logic             c0_done;
   logic             c1_req;
   logic             c1_write;
   logic [ABITS-1:0] c1_addr;
   logic [DBITS-1:0] c1_wdata;
   logic             c1_done;
   logic [DBITS-1:0] rdata;
   logic             owner;
   logic             m_ena;
   logic             m_write;
   logic [ABITS-1:0] m_addr;
   logic [DBITS-1:0] wr_data;
   logic             m_ack;
   logic             m_busy;
   logic [DBITS-1:0] rd_data;

   modport slave (
      input  c0_req, c0_write, c0_addr, c0_wdata,
      input  c1_req, c1_write, c1_addr, c1_wdata,
      input  m_ack, m_busy, rd_data,
      output c0_done, c1_done, rdata, owner,
      output m_ena, m_write, m_addr, wr_data
   );

   modport master (
      output c0_req, c0_write, c0_addr, c0_wdata,
      output c1_req, c1_write, c1_addr, c1_wdata,
      output m_ack, m_busy, rd_data,
      input  c0_done, c1_done, rdata, owner,
      input  m_ena, m_write, m_addr, wr_data
   );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one hm515264 DRAM command port between the tape
// engine (client 0) and the tape-dump/viewer engine (client 1).
module dram_arbiter #(
   parameter int ABITS = 18,
   parameter int DBITS = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   dram_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e           state_q;
   logic             m_ena_q;
   logic             m_write_q;
   logic [ABITS-1:0] m_addr_q;
   logic [DBITS-1:0] wr_data_q;
   logic [DBITS-1:0] rdata_q;
   logic             c0_done_q;
   logic             c1_done_q;
   logic             owner_q;
   logic             last_q;

   logic             any_req_d;
   logic             pick1_d;

   // Client 1 wins when it is alone, or when both ask and client 0 was served last.
   always_comb begin
      any_req_d = bus.c0_req | bus.c1_req;
      pick1_d   = bus.c1_req & (~bus.c0_req | ~last_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_ena_q   <= 1'b0;
         m_write_q <= 1'b0;
         m_addr_q  <= '0;
         wr_data_q <= '0;
         rdata_q   <= '0;
         c0_done_q <= 1'b0;
         c1_done_q <= 1'b0;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         c0_done_q <= 1'b0;
         c1_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // m_busy covers DRAM power-up init and refresh; never issue over it.
               if (!bus.m_busy && any_req_d) begin
                  owner_q   <= pick1_d;
                  last_q    <= pick1_d;
                  m_ena_q   <= 1'b1;
                  m_addr_q  <= pick1_d ? bus.c1_addr  : bus.c0_addr;
                  m_write_q <= pick1_d ? bus.c1_write : bus.c0_write;
                  wr_data_q <= pick1_d ? bus.c1_wdata : bus.c0_wdata;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.m_ack) begin
                  m_ena_q <= 1'b0;
                  if (!m_write_q) rdata_q <= bus.rd_data;
                  state_q <= bus.m_busy ? WAIT : DONE;
               end
            end
            WAIT: begin
               if (!m_write_q) rdata_q <= bus.rd_data;
               if (!bus.m_busy) state_q <= DONE;
            end
            DONE: begin
               c0_done_q <= ~owner_q;
               c1_done_q <= owner_q;
               m_write_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.m_ena   = m_ena_q;
   assign bus.m_write = m_write_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.rdata   = rdata_q;
   assign bus.c0_done = c0_done_q;
   assign bus.c1_done = c1_done_q;
   assign bus.owner   = owner_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed vector table, multi-cycle corner sequences and
// random traffic, all checked against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_dram_arbiter;

   logic clk;
   logic rst_n;

   dram_arbiter_if #(.ABITS(18), .DBITS(4)) bus ();

   dram_arbiter #(.ABITS(18), .DBITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Memory responder configuration and storage.
   logic [3:0] mem [logic [17:0]];
   logic       busy_force = 1'b0;
   logic       busy_mem   = 1'b0;
   logic       rand_mode  = 1'b0;
   int         cfg_a = 0;
   int         cfg_b = 0;
   int         cur_a, cur_b, resp_cnt, busy_left;
   logic       resp_started, resp_acked;
   logic [3:0] resp_rd;

   assign bus.m_busy = busy_force | busy_mem;

   function automatic logic [3:0] memval(input logic [17:0] a);
      if (mem.exists(a)) return mem[a];
      return a[3:0] ^ 4'h5;
   endfunction

   // Transaction-level model state.
   logic        op_act, op_cl, op_wr, acked, last_m, prev_ena;
   logic [17:0] op_addr;
   logic [3:0]  op_wd, rdata_hold;
   int          done_cnt0, done_cnt1;

   always begin
      logic r0, r1, ack_e, busy_e, got_g, exp_g, win, d0, d1;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         op_act = 1'b0; acked = 1'b0; last_m = 1'b1; prev_ena = 1'b0;
         rdata_hold = 4'h0;
         bus.m_ack = 1'b0; busy_mem = 1'b0; busy_left = 0;
         resp_started = 1'b0; resp_acked = 1'b0; resp_cnt = 0;
      end else begin
         r0 = bus.c0_req; r1 = bus.c1_req;
         ack_e = bus.m_ack; busy_e = bus.m_busy;
         d0 = bus.c0_done; d1 = bus.c1_done;
         got_g = bus.m_ena && !prev_ena;
         exp_g = !op_act && !busy_e && (r0 || r1);
         chk("grant_when_free", 32'(got_g), 32'(exp_g));
         if (got_g) begin
            win = (r0 && r1) ? !last_m : r1;
            chk("grant_owner", 32'(bus.owner), 32'(win));
            op_cl = win; op_act = 1'b1; acked = 1'b0; last_m = win;
            op_addr = win ? bus.c1_addr  : bus.c0_addr;
            op_wr   = win ? bus.c1_write : bus.c0_write;
            op_wd   = win ? bus.c1_wdata : bus.c0_wdata;
            chk("grant_addr", 32'(bus.m_addr), 32'(op_addr));
            chk("grant_write", 32'(bus.m_write), 32'(op_wr));
            chk("grant_wdata", 32'(bus.wr_data), 32'(op_wd));
         end else if (op_act) begin
            if (ack_e) acked = 1'b1;
            if (!(d0 || d1)) begin
               chk("ena_until_ack", 32'(bus.m_ena), 32'(!acked));
               chk("addr_stable", 32'(bus.m_addr), 32'(op_addr));
               chk("write_stable", 32'(bus.m_write), 32'(op_wr));
               chk("wdata_stable", 32'(bus.wr_data), 32'(op_wd));
            end
         end
         chk("single_done", 32'(d0 && d1), 32'(0));
         if (d0 || d1) begin
            chk("done_in_op", 32'(op_act && acked), 32'(1));
            chk("done_client", 32'(d1), 32'(op_cl));
            if (!op_wr) rdata_hold = resp_rd;
            chk("done_rdata", 32'(bus.rdata), 32'(rdata_hold));
            if (d0) done_cnt0++;
            if (d1) done_cnt1++;
            op_act = 1'b0;
         end
         prev_ena = bus.m_ena;

         // Memory responder: ack after cur_a cycles of m_ena, then busy for cur_b cycles.
         bus.m_ack = 1'b0;
         if (busy_left > 0) begin busy_mem = 1'b1; busy_left--; end
         else busy_mem = 1'b0;
         if (bus.m_ena && !resp_acked) begin
            if (!resp_started) begin
               resp_started = 1'b1; resp_cnt = 0;
               cur_a = rand_mode ? $urandom_range(0, 3) : cfg_a;
               cur_b = rand_mode ? $urandom_range(0, 3) : cfg_b;
            end
            if (resp_cnt == cur_a) begin
               bus.m_ack = 1'b1; resp_acked = 1'b1;
               busy_mem  = (cur_b > 0);
               busy_left = (cur_b > 0) ? cur_b - 1 : 0;
               if (bus.m_write) mem[bus.m_addr] = bus.wr_data;
               else begin
                  resp_rd = memval(bus.m_addr);
                  bus.rd_data = resp_rd;
               end
            end else resp_cnt++;
         end
         if (!bus.m_ena) begin resp_acked = 1'b0; resp_started = 1'b0; end
      end
   end

   task automatic set_cli(input int cl, input logic req, input logic wr,
                          input logic [17:0] a, input logic [3:0] d);
      if (cl == 0) begin
         bus.c0_req = req; bus.c0_write = wr; bus.c0_addr = a; bus.c0_wdata = d;
      end else begin
         bus.c1_req = req; bus.c1_write = wr; bus.c1_addr = a; bus.c1_wdata = d;
      end
   endtask

   task automatic drop_req(input int cl);
      if (cl == 0) bus.c0_req = 1'b0;
      else bus.c1_req = 1'b0;
   endtask

   task automatic wait_done(output logic [1:0] dn, output logic [3:0] rd, output int lat);
      dn = 2'b00; rd = 4'h0; lat = 0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         if (bus.c0_done || bus.c1_done) begin
            dn = {bus.c1_done, bus.c0_done}; rd = bus.rdata; lat = i;
            break;
         end
      end
   endtask

   task automatic wait_ena(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (bus.m_ena) begin ok = 1'b1; break; end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic client_run(input int cl, input int nops);
      for (int k = 0; k < nops; k++) begin
         logic ok;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         @(negedge clk);
         set_cli(cl, 1'b1, 1'($urandom_range(0, 1)), 18'($urandom), 4'($urandom));
         ok = 1'b0;
         for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if ((cl == 0) ? bus.c0_done : bus.c1_done) begin ok = 1'b1; break; end
         end
         chk("rand_done_seen", 32'(ok), 32'(1));
         @(negedge clk);
         drop_req(cl);
      end
   endtask

   typedef struct {
      int          cl;
      logic        wr;
      logic [17:0] addr;
      logic [3:0]  wd;
      int          a;
      int          b;
      int          lat;
      logic [1:0]  dn;
      logic [3:0]  rd;
   } vec_t;

   vec_t tbl [6];

   initial begin
      logic [1:0] dn;
      logic [3:0] rd;
      int         lat;
      logic       ok;
      int         n0, n1;

      tbl[0] = '{0, 1'b0, 18'h00005, 4'h0, 0, 0,  3, 2'b01, 4'hA};
      tbl[1] = '{1, 1'b1, 18'h3FFFF, 4'h3, 4, 6, 13, 2'b10, 4'hA};
      tbl[2] = '{1, 1'b0, 18'h3FFFF, 4'h0, 0, 0,  3, 2'b10, 4'h3};
      tbl[3] = '{0, 1'b1, 18'h00000, 4'hF, 1, 2,  6, 2'b01, 4'h3};
      tbl[4] = '{0, 1'b0, 18'h00000, 4'h0, 2, 3,  8, 2'b01, 4'hF};
      tbl[5] = '{1, 1'b0, 18'h12345, 4'h0, 0, 1,  4, 2'b10, 4'h6};
      mem[18'h00005] = 4'hA;
      mem[18'h12345] = 4'h6;

      set_cli(0, 1'b0, 1'b0, 18'h0, 4'h0);
      set_cli(1, 1'b0, 1'b0, 18'h0, 4'h0);
      bus.m_ack = 1'b0; bus.rd_data = 4'h0;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      busy_force = 1'b1;
      @(negedge clk); #1;
      chk("rst_m_ena", 32'(bus.m_ena), 32'(0));
      chk("rst_m_write", 32'(bus.m_write), 32'(0));
      chk("rst_m_addr", 32'(bus.m_addr), 32'(0));
      chk("rst_wr_data", 32'(bus.wr_data), 32'(0));
      chk("rst_c0_done", 32'(bus.c0_done), 32'(0));
      chk("rst_c1_done", 32'(bus.c1_done), 32'(0));
      chk("rst_rdata", 32'(bus.rdata), 32'(0));
      chk("rst_owner", 32'(bus.owner), 32'(0));
      @(negedge clk); rst_n = 1'b1;

      // Init hold: no grant while the memory reports busy.
      @(negedge clk);
      set_cli(0, 1'b1, 1'b0, 18'h0ABCD, 4'h0);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         chk("init_hold_ena", 32'(bus.m_ena), 32'(0));
      end
      @(negedge clk); busy_force = 1'b0;
      @(posedge clk); #1;
      chk("init_release_ena", 32'(bus.m_ena), 32'(1));
      chk("init_release_addr", 32'(bus.m_addr), 32'(18'h0ABCD));
      wait_done(dn, rd, lat);
      chk("init_done", 32'(dn), 32'(2'b01));
      chk("init_rdata", 32'(rd), 32'(4'h8));
      @(negedge clk); drop_req(0);

      // Directed single operations.
      for (int v = 0; v < 6; v++) begin
         cfg_a = tbl[v].a; cfg_b = tbl[v].b;
         @(negedge clk);
         set_cli(tbl[v].cl, 1'b1, tbl[v].wr, tbl[v].addr, tbl[v].wd);
         wait_done(dn, rd, lat);
         chk($sformatf("tbl%0d_latency", v), 32'(lat), 32'(tbl[v].lat));
         chk($sformatf("tbl%0d_done", v), 32'(dn), 32'(tbl[v].dn));
         chk($sformatf("tbl%0d_rdata", v), 32'(rd), 32'(tbl[v].rd));
         @(negedge clk); drop_req(tbl[v].cl);
      end

      // Contention: both clients request continuously, reads only.
      cfg_a = 0; cfg_b = 0;
      pulse_reset();
      set_cli(0, 1'b1, 1'b0, 18'h00100, 4'h0);
      set_cli(1, 1'b1, 1'b0, 18'h00200, 4'h0);
      n0 = 0; n1 = 0;
      for (int i = 0; i < 8; i++) begin
         wait_done(dn, rd, lat);
         chk("cont_order", 32'(dn), (i % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
         chk("cont_owner", 32'(bus.owner), 32'(i % 2));
         if (dn == 2'b01) n0++;
         if (dn == 2'b10) n1++;
      end
      @(negedge clk); drop_req(0); drop_req(1);
      chk("cont_c0_count", 32'(n0), 32'(4));
      chk("cont_c1_count", 32'(n1), 32'(4));

      // Client 1 drops its request in ISSUE; client 0 arrives meanwhile.
      cfg_a = 3; cfg_b = 0;
      @(negedge clk);
      set_cli(1, 1'b1, 1'b0, 18'h00777, 4'h0);
      wait_ena(ok);
      chk("drop_granted", 32'(ok), 32'(1));
      @(negedge clk);
      drop_req(1);
      set_cli(0, 1'b1, 1'b0, 18'h00888, 4'h0);
      wait_done(dn, rd, lat);
      chk("drop_c1_done", 32'(dn), 32'(2'b10));
      wait_done(dn, rd, lat);
      chk("drop_c0_next", 32'(dn), 32'(2'b01));
      chk("drop_c0_owner", 32'(bus.owner), 32'(0));
      @(negedge clk); drop_req(0);

      // Reset in the middle of a slow read.
      cfg_a = 0; cfg_b = 5;
      @(negedge clk);
      set_cli(1, 1'b1, 1'b0, 18'h01234, 4'h0);
      wait_ena(ok);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; drop_req(1);
      #1;
      chk("midrst_ena", 32'(bus.m_ena), 32'(0));
      chk("midrst_owner", 32'(bus.owner), 32'(0));
      chk("midrst_addr", 32'(bus.m_addr), 32'(0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_done", 32'({bus.c1_done, bus.c0_done}), 32'(0));
      end
      @(negedge clk); rst_n = 1'b1;
      cfg_a = 0; cfg_b = 0;
      @(negedge clk);
      set_cli(0, 1'b1, 1'b0, 18'h00005, 4'h0);
      wait_done(dn, rd, lat);
      chk("postrst_latency", 32'(lat), 32'(3));
      chk("postrst_done", 32'(dn), 32'(2'b01));
      chk("postrst_rdata", 32'(rd), 32'(4'hA));
      @(negedge clk); drop_req(0);

      // Random traffic from both clients against the model.
      rand_mode = 1'b1;
      done_cnt0 = 0; done_cnt1 = 0;
      fork
         client_run(0, 40);
         client_run(1, 40);
      join
      repeat (4) @(negedge clk);
      chk("rand_c0_ops", 32'(done_cnt0), 32'(40));
      chk("rand_c1_ops", 32'(done_cnt1), 32'(40));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete, got %0d errors so far", err_cnt);
      $fatal(1, "timeout");
   end

endmodule
